// File: rtl/mmu_mem_responder.sv
// mmu_mem_responder: memory-side responder for the MMU request channel.
// One request at a time; read/write/translation fetch after LAT cycles, with a preload port.
module mmu_mem_responder #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024,
  parameter int LAT    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rdyin,
  input  logic [1:0]        op,
  input  logic [ADDR_W-1:0] ind,
  input  logic [DATA_W-1:0] datain,
  output logic              ackout,
  output logic              esito,
  output logic [DATA_W-1:0] dataout,
  output logic              busy,
  input  logic              init_we,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic [DATA_W-1:0] init_data
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(DEPTH);
  localparam logic [7:0] CNT_INIT = 8'(LAT - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP, WAIT_DROP} state_t;

  state_t            state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [AW-1:0]     ind_q, ind_d;
  logic [DATA_W-1:0] wd_q, wd_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              ack_q, ack_d, esito_q, esito_d, busy_q, busy_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_word, mem_wdata;
  logic [AW-1:0]     mem_addr;
  logic              req_fault, commit, mem_we;

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    ind_d     = ind_q;
    wd_d      = wd_q;
    cnt_d     = cnt_q;
    esito_d   = esito_q;
    dout_d    = dout_q;
    rd_word   = mem[ind_q];
    req_fault = op == 2'b10 || {1'b0, ind} >= LIMIT;
    commit    = state_q == ACCESS && cnt_q == 8'd0;
    case (state_q)
      IDLE: if (rdyin) begin
        op_d    = op;
        ind_d   = ind[AW-1:0];
        wd_d    = datain;
        cnt_d   = CNT_INIT;
        state_d = req_fault ? RESP : ACCESS;
        esito_d = req_fault ? 1'b1 : esito_q;
        dout_d  = req_fault ? '0 : dout_q;
      end
      ACCESS: begin
        cnt_d   = cnt_q - 8'd1;
        state_d = commit ? RESP : ACCESS;
        dout_d  = commit ? (op_q == 2'b01 ? '0 : rd_word) : dout_q;
        esito_d = commit ? (op_q == 2'b11 && !rd_word[DATA_W-1]) : esito_q;
      end
      default: state_d = rdyin ? WAIT_DROP : IDLE;
    endcase
    ack_d  = state_d == RESP;
    busy_d = state_d != IDLE;
    // A sampled request on the same edge blocks the preload
    mem_we    = rst_n && ((commit && op_q == 2'b01) ||
                (state_q == IDLE && !rdyin && init_we && {1'b0, init_addr} < LIMIT));
    mem_addr  = commit ? ind_q : init_addr[AW-1:0];
    mem_wdata = commit ? wd_q : init_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      ind_q   <= '0;
      wd_q    <= '0;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      esito_q <= 1'b0;
      busy_q  <= 1'b0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      ind_q   <= ind_d;
      wd_q    <= wd_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      esito_q <= esito_d;
      busy_q  <= busy_d;
      dout_q  <= dout_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  assign ackout  = ack_q;
  assign esito   = esito_q;
  assign dataout = dout_q;
  assign busy    = busy_q;
endmodule

// File: tb/tb_mmu_mem_responder.sv
// tb_mmu_mem_responder: directed stimulus with a latency/array reference model checked every cycle.
module tb_mmu_mem_responder;
  localparam int DEPTH = 1024;
  localparam int LAT   = 4;

  logic        clk = 1'b0, rst_n = 1'b0, rdyin = 1'b0, init_we = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [15:0] ind = '0, init_addr = '0;
  logic [31:0] datain = '0, init_data = '0;
  logic        ackout, esito, busy;
  logic [31:0] dataout;
  int          checks = 0, failures = 0;

  always #5 clk = ~clk;

  mmu_mem_responder #(.ADDR_W(16), .DATA_W(32), .DEPTH(DEPTH), .LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .rdyin(rdyin), .op(op), .ind(ind), .datain(datain),
    .ackout(ackout), .esito(esito), .dataout(dataout), .busy(busy),
    .init_we(init_we), .init_addr(init_addr), .init_data(init_data)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: response lands LAT edges after acceptance (at acceptance for faults)
  logic [31:0] ref_mem [DEPTH];
  int          phase = 0, rem = 0, m_ind = 0;
  logic [1:0]  m_op;
  logic [31:0] m_wd;
  logic        e_ack = 0, e_esito = 0, e_busy = 0;
  logic [31:0] e_data = '0;

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      phase = 0; e_ack = 0; e_esito = 0; e_data = '0; e_busy = 0;
    end
    chk("ackout", 32'(ackout), 32'(e_ack));
    chk("esito", 32'(esito), 32'(e_esito));
    chk("dataout", dataout, e_data);
    chk("busy", 32'(busy), 32'(e_busy));
    if (rst_n) begin
      case (phase)
        0: begin
          e_ack = 0;
          if (rdyin) begin
            m_op = op; m_ind = int'(ind); m_wd = datain;
            if (op == 2'b10 || int'(ind) >= DEPTH) begin
              e_ack = 1; e_esito = 1; e_data = '0; phase = 2;
            end else begin
              rem = LAT; phase = 1;
            end
          end else if (init_we && int'(init_addr) < DEPTH) ref_mem[init_addr] = init_data;
        end
        1: begin
          rem--;
          if (rem == 0) begin
            e_ack   = 1;
            e_data  = (m_op == 2'b01) ? 32'h0 : ref_mem[m_ind];
            e_esito = (m_op == 2'b11) && !ref_mem[m_ind][31];
            if (m_op == 2'b01) ref_mem[m_ind] = m_wd;
            phase = 2;
          end
        end
        2: begin e_ack = 0; phase = rdyin ? 3 : 0; end
        default: if (!rdyin) phase = 0;
      endcase
      e_busy = phase != 0;
    end
  end

  task automatic preload(input int a, input logic [31:0] d);
    @(posedge clk); #1;
    init_we = 1; init_addr = 16'(a); init_data = d;
    @(posedge clk); #1;
    init_we = 0;
  endtask

  task automatic req(input string nm, input logic [1:0] o, input int a, input logic [31:0] d,
                     input logic [31:0] exp_d, input logic exp_e, input int exp_lat,
                     input int hold, input logic iw);
    int n = 0;
    int acks = 0;
    @(posedge clk); #1;
    rdyin = 1; op = o; ind = 16'(a); datain = d;
    init_we = iw; init_addr = 16'(a); init_data = 32'hAAAA_5555;
    do begin
      @(posedge clk); #1;
      n++;
      if (n == 1) begin
        chk({nm, " busy"}, 32'(busy), 32'd1);
        op = 2'b10; ind = 16'hFFFF; datain = ~d;
      end
    end while (!ackout && n < 50);
    chk({nm, " latency"}, 32'(n), 32'(exp_lat));
    chk({nm, " data"}, dataout, exp_d);
    chk({nm, " esito"}, 32'(esito), 32'(exp_e));
    if (hold > 0) begin
      repeat (hold) begin
        @(posedge clk); #1;
        if (ackout) acks++;
      end
      chk({nm, " extra acks"}, 32'(acks), 32'd0);
      chk({nm, " waitdrop busy"}, 32'(busy), 32'd1);
    end
    rdyin = 0; init_we = 0;
  endtask

  initial begin
    int acks;
    repeat (3) @(posedge clk);
    #1;
    chk("reset ackout", 32'(ackout), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset dataout", dataout, 32'd0);
    rst_n = 1;
    preload(5, 32'h1234_5678);
    preload(3, 32'h8000_0042);
    preload(9, 32'h0000_0011);
    preload(6, 32'h0000_0066);
    preload(1023, 32'hCAFE_F00D);
    preload(1030, 32'h0000_0BAD);
    req("read5", 2'b00, 5, 0, 32'h1234_5678, 0, LAT + 1, 0, 0);
    req("write7", 2'b01, 7, 32'hDEAD_BEEF, 32'h0, 0, LAT + 1, 0, 0);
    req("read7", 2'b00, 7, 0, 32'hDEAD_BEEF, 0, LAT + 1, 0, 0);
    req("fetch3v", 2'b11, 3, 0, 32'h8000_0042, 0, LAT + 1, 0, 0);
    preload(3, 32'h0000_0042);
    req("fetch3i", 2'b11, 3, 0, 32'h0000_0042, 1, LAT + 1, 0, 0);
    req("op10", 2'b10, 5, 0, 32'h0, 1, 1, 0, 0);
    req("oob1024", 2'b00, 1024, 0, 32'h0, 1, 1, 0, 0);
    req("oobwrite", 2'b01, 2000, 32'h5555_5555, 32'h0, 1, 1, 0, 0);
    req("reread5", 2'b00, 5, 0, 32'h1234_5678, 0, LAT + 1, 0, 0);
    req("read1023", 2'b00, 1023, 0, 32'hCAFE_F00D, 0, LAT + 1, 0, 0);
    req("read6", 2'b00, 6, 0, 32'h0000_0066, 0, LAT + 1, 0, 0);
    req("hold", 2'b00, 5, 0, 32'h1234_5678, 0, LAT + 1, 20, 0);
    req("afterhold", 2'b11, 3, 0, 32'h0000_0042, 1, LAT + 1, 0, 0);
    @(posedge clk); #1;
    rdyin = 1; op = 2'b01; ind = 16'd9; datain = 32'hFFFF_FFFF;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 0; rdyin = 0;
    #1;
    chk("abort ackout", 32'(ackout), 32'd0);
    chk("abort busy", 32'(busy), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    acks = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (ackout) acks++;
    end
    chk("abort no ack", 32'(acks), 32'd0);
    req("read9", 2'b00, 9, 0, 32'h0000_0011, 0, LAT + 1, 0, 0);
    req("reqwins", 2'b00, 5, 0, 32'h1234_5678, 0, LAT + 1, 0, 1);
    req("noclobber5", 2'b00, 5, 0, 32'h1234_5678, 0, LAT + 1, 0, 0);
    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
